// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo PWM controller: FSM states,
// packet byte offsets and the angle-to-ticks conversion.
package servo_pkg;

  typedef enum logic [2:0] {
    S_RUN,
    S_SNAP,
    S_CHECK,
    S_CALC,
    S_LOAD
  } state_t;

  localparam int HDR_LSB = 32;
  localparam int CH0_LSB = 24;
  localparam int CH1_LSB = 16;
  localparam int CH2_LSB = 8;
  localparam int SUM_LSB = 0;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Angle 0x00 maps to min_ticks; each angle step adds span/256 ticks, truncated.
  function automatic int unsigned angle_to_ticks(input logic [7:0] angle,
                                                 input int unsigned min_ticks,
                                                 input int unsigned span);
    int unsigned prod;
    prod = int'(angle) * span;
    return min_ticks + (prod >> 8);
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: holds the active pulse width and drives the registered
// comparator output. Slew limiting is built in when SERVO_SLEW_LIMIT_EN is defined.
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int unsigned CW         = 21,
  parameter int unsigned CENTRE     = 150000,
  parameter int unsigned SLEW_TICKS = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic          load,
  input  logic [CW-1:0] tgt,
  output logic          pwm
);

  logic [CW-1:0] width;
  logic [CW-1:0] next_width;

`ifdef SERVO_SLEW_LIMIT_EN
  localparam logic [CW-1:0] STEP = CW'(SLEW_TICKS);

  // Step toward the target by at most STEP, landing exactly on it when close.
  always_comb begin
    next_width = tgt;
    if (tgt > width && (tgt - width) > STEP)
      next_width = width + STEP;
    else if (tgt < width && (width - tgt) > STEP)
      next_width = width - STEP;
  end
`else
  assign next_width = tgt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      width <= CW'(CENTRE);
      pwm   <= 1'b0;
    end else begin
      if (load)
        width <= next_width;
      pwm <= (cnt < width);
    end
  end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Three-channel hobby-servo PWM driver fed by a held 5-byte packet.
// Optional per-frame slew limiting: define SERVO_SLEW_LIMIT_EN.
module servo_pwm_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned PERIOD_US    = 20000,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2000,
  parameter logic [7:0]  HEADER       = DEFAULT_HEADER,
  parameter int unsigned SLEW_TICKS   = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] din,
  output logic [2:0]  pwm_out,
  output logic        pkt_err,
  output logic [7:0]  err_cnt,
  output logic        frame_start
);

  localparam int unsigned TICKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PERIOD_TICKS = TICKS_PER_US * PERIOD_US;
  localparam int unsigned MIN_TICKS    = TICKS_PER_US * MIN_PULSE_US;
  localparam int unsigned MAX_TICKS    = TICKS_PER_US * MAX_PULSE_US;
  localparam int unsigned SPAN         = MAX_TICKS - MIN_TICKS;
  localparam int unsigned CENTRE       = MIN_TICKS + ((128 * SPAN) >> 8);
  localparam int unsigned CW           = $clog2(PERIOD_TICKS + 1);

  localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_TICKS - 1);
  localparam logic [CW-1:0] SNAP_CNT = CW'(PERIOD_TICKS - 5);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [39:0]   snap;
  logic          ok;
  logic          zero;
  logic [CW-1:0] tgt [3];
  logic          load;

  // The snapshot pipeline ends in S_LOAD on the last tick of the frame, so any
  // accepted width takes effect exactly at the next cnt == 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      state       <= S_RUN;
      snap        <= '0;
      ok          <= 1'b0;
      zero        <= 1'b0;
      pkt_err     <= 1'b0;
      err_cnt     <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < 3; i++)
        tgt[i] <= CW'(CENTRE);
    end else begin
      cnt         <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      frame_start <= (cnt == LAST_CNT);
      pkt_err     <= 1'b0;
      case (state)
        S_RUN: begin
          if (cnt == SNAP_CNT)
            state <= S_SNAP;
        end
        S_SNAP: begin
          snap  <= din;
          state <= S_CHECK;
        end
        S_CHECK: begin
          ok    <= (snap[HDR_LSB +: 8] == HEADER) &&
                   (snap[SUM_LSB +: 8] == (snap[HDR_LSB +: 8] ^ snap[CH0_LSB +: 8] ^
                                           snap[CH1_LSB +: 8] ^ snap[CH2_LSB +: 8]));
          zero  <= (snap == '0);
          state <= S_CALC;
        end
        S_CALC: begin
          tgt[0] <= CW'(angle_to_ticks(snap[CH0_LSB +: 8], MIN_TICKS, SPAN));
          tgt[1] <= CW'(angle_to_ticks(snap[CH1_LSB +: 8], MIN_TICKS, SPAN));
          tgt[2] <= CW'(angle_to_ticks(snap[CH2_LSB +: 8], MIN_TICKS, SPAN));
          state  <= S_LOAD;
        end
        S_LOAD: begin
          if (!ok && !zero) begin
            pkt_err <= 1'b1;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end
          state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign load = (state == S_LOAD) && ok;

  for (genvar g = 0; g < 3; g++) begin : g_chan
    servo_pwm_chan #(
      .CW         (CW),
      .CENTRE     (CENTRE),
      .SLEW_TICKS (SLEW_TICKS)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .load (load),
      .tgt  (tgt[g]),
      .pwm  (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Self-checking bench for servo_pwm_ctrl: frame-level reference model, a table of
// directed packets, snapshot-boundary, saturation, reset and randomized frames.
module tb_servo_pwm_ctrl;

  localparam int P      = 150;
  localparam int MINT   = 20;
  localparam int SPAN   = 100;
  localparam int CENTRE = 70;
  localparam int SLEW   = 7;
  localparam int NO_CHG = P + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] din = '0;
  logic [2:0]  pwm_out;
  logic        pkt_err;
  logic [7:0]  err_cnt;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  int m_w [3];
  int m_err;
  int last_hi [3];
  int last_perr;

  typedef struct {
    logic [39:0] pkt;
    int          w0;
    int          w1;
    int          w2;
    int          perr;
    int          ec;
  } vec_t;

  vec_t tbl [10];

  servo_pwm_ctrl #(
    .CLK_FREQ_HZ  (1_000_000),
    .PERIOD_US    (P),
    .MIN_PULSE_US (MINT),
    .MAX_PULSE_US (MINT + SPAN),
    .HEADER       (8'hA5),
    .SLEW_TICKS   (SLEW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .pwm_out     (pwm_out),
    .pkt_err     (pkt_err),
    .err_cnt     (err_cnt),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int conv(input int angle);
    return MINT + (angle * SPAN) / 256;
  endfunction

  function automatic int move_toward(input int cur, input int target);
`ifdef SERVO_SLEW_LIMIT_EN
    if (target > cur + SLEW) return cur + SLEW;
    if (target < cur - SLEW) return cur - SLEW;
    return target;
`else
    return target;
`endif
  endfunction

  function automatic logic [39:0] mk(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    logic [7:0] h;
    h = 8'hA5;
    return {h, a0, a1, a2, h ^ a0 ^ a1 ^ a2};
  endfunction

  function automatic logic [39:0] rand_pkt();
    logic [39:0] p;
    case ($urandom_range(0, 3))
      0: p = mk(8'($urandom), 8'($urandom), 8'($urandom));
      1: begin
        p = mk(8'($urandom), 8'($urandom), 8'($urandom));
        p[7:0] = p[7:0] ^ 8'(1 << $urandom_range(0, 7));
      end
      2: p = '0;
      default: p = {8'($urandom), $urandom};
    endcase
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_w[i] = CENTRE;
    m_err = 0;
  endtask

  // Frame-level effect of one snapshot on the model widths and error count.
  task automatic model_snap(input logic [39:0] s, output int exp_perr);
    int h, a [3], c;
    bit good;
    h    = int'(s[39:32]);
    a[0] = int'(s[31:24]);
    a[1] = int'(s[23:16]);
    a[2] = int'(s[15:8]);
    c    = int'(s[7:0]);
    good = (h == 'hA5) && (c == (h ^ a[0] ^ a[1] ^ a[2]));
    exp_perr = 0;
    if (good) begin
      for (int i = 0; i < 3; i++) m_w[i] = move_toward(m_w[i], conv(a[i]));
    end else if (s != '0) begin
      exp_perr = 1;
      if (m_err < 255) m_err++;
    end
  endtask

  // Runs one full frame: din=d0 from the start, switched to d1 after offset off.
  task automatic apply_stimulus(input logic [39:0] d0, input int off, input logic [39:0] d1);
    int hi [3];
    int exp_w [3];
    int perr, fs_cnt, fs_last, exp_perr;
    logic [39:0] snapv;
    perr = 0; fs_cnt = 0; fs_last = 0;
    for (int i = 0; i < 3; i++) begin
      hi[i]    = 0;
      exp_w[i] = m_w[i];
    end
    din = d0;
    for (int j = 1; j <= P; j++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) if (pwm_out[i]) hi[i]++;
      if (pkt_err) perr++;
      if (frame_start) begin
        fs_cnt++;
        fs_last = j;
      end
      if (j == off) din = d1;
    end
    snapv = (off <= P - 4) ? d1 : d0;
    model_snap(snapv, exp_perr);
    for (int i = 0; i < 3; i++)
      check_output($sformatf("width_ch%0d", i), hi[i], exp_w[i]);
    check_output("pkt_err_pulses", perr, exp_perr);
    check_output("err_cnt", int'(err_cnt), m_err);
    check_output("frame_start_count", fs_cnt, 1);
    check_output("frame_start_pos", fs_last, P);
    for (int i = 0; i < 3; i++) last_hi[i] = hi[i];
    last_perr = perr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_pwm"}, int'(pwm_out), 0);
    check_output({tag, "_pkt_err"}, int'(pkt_err), 0);
    check_output({tag, "_err_cnt"}, int'(err_cnt), 0);
    check_output({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    tbl[0] = '{40'h0,          70,  70, 70, 0, 0};
    tbl[1] = '{40'h0,          70,  70, 70, 0, 0};
    tbl[2] = '{40'h0,          70,  70, 70, 0, 0};
    tbl[3] = '{40'hA5FF00401A, 70,  70, 70, 0, 0};
    tbl[4] = '{40'hA5FF00401B, 119, 20, 45, 1, 1};
    tbl[5] = '{40'hA5FF00401B, 119, 20, 45, 1, 2};
    tbl[6] = '{40'h5A80808025, 119, 20, 45, 1, 3};
    tbl[7] = '{40'h0,          119, 20, 45, 0, 3};
    tbl[8] = '{40'hA580808025, 119, 20, 45, 0, 3};
    tbl[9] = '{40'h0,          70,  70, 70, 0, 3};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    $display("[TB] directed packet table");
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(tbl[k].pkt, NO_CHG, '0);
`ifndef SERVO_SLEW_LIMIT_EN
      check_output($sformatf("tbl%0d_w0", k), last_hi[0], tbl[k].w0);
      check_output($sformatf("tbl%0d_w1", k), last_hi[1], tbl[k].w1);
      check_output($sformatf("tbl%0d_w2", k), last_hi[2], tbl[k].w2);
`endif
      check_output($sformatf("tbl%0d_perr", k), last_perr, tbl[k].perr);
      check_output($sformatf("tbl%0d_ec", k), int'(err_cnt), tbl[k].ec);
    end

    $display("[TB] snapshot boundary");
    apply_stimulus(mk(8'h10, 8'h20, 8'h30), P - 3, mk(8'hE0, 8'hC0, 8'hA0));
    apply_stimulus(mk(8'hE0, 8'hC0, 8'hA0), NO_CHG, '0);
    apply_stimulus(mk(8'hE0, 8'hC0, 8'hA0), NO_CHG, '0);
    apply_stimulus(mk(8'h10, 8'h20, 8'h30), P - 4, mk(8'h33, 8'h44, 8'h55));
    apply_stimulus(mk(8'h33, 8'h44, 8'h55), NO_CHG, '0);

    $display("[TB] ch0 ramp 0x80 to 0xFF");
    apply_stimulus(mk(8'h80, 8'h80, 8'h80), NO_CHG, '0);
    for (int k = 0; k < 10; k++)
      apply_stimulus(mk(8'hFF, 8'h80, 8'h80), NO_CHG, '0);
    check_output("ramp_final_ch0", last_hi[0], 119);

    $display("[TB] error counter saturation");
    for (int k = 0; k < 260; k++)
      apply_stimulus(40'h5A80808025, NO_CHG, '0);
    check_output("err_cnt_saturated", int'(err_cnt), 255);
    check_output("width_held_after_errors", last_hi[0], 119);

    $display("[TB] randomized frames");
    for (int k = 0; k < 20; k++)
      apply_stimulus(rand_pkt(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, P)) : NO_CHG,
                     rand_pkt());

    $display("[TB] reset during snapshot pipeline");
    din = mk(8'h00, 8'hFF, 8'h00);
    repeat (P - 3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    model_reset();
    apply_stimulus('0, NO_CHG, '0);
    check_output("midreset_centre_ch1", last_hi[1], CENTRE);
    apply_stimulus(mk(8'h00, 8'hFF, 8'h00), NO_CHG, '0);
    apply_stimulus('0, NO_CHG, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
